conv_seq_ctrl: RTL and testbench
================================

# conv_seq_ctrl

Sequencer for the two-layer convolution datapath. A single-channel conv engine computes conv1 (with its internal ReLU) and then conv2 for one channel at a time. This block drives that engine over all CHAN channels and sequences the shared output accumulator: overwrite on the first channel, accumulate on later channels, and a final ReLU pass. It raises out_valid when the accumulated output buffer holds the final result.

## Interface
Parameters:
- CHAN, 10, number of channels processed per inference
- OUT2_H, 12, conv2 output rows (accumulator height)
- OUT2_W, 11, conv2 output columns (accumulator width)
- CH_W, $clog2(CHAN), channel index width
- RW / CW, $clog2(OUT2_H) / $clog2(OUT2_W), row/col address widths

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous and active-high
- trigger  in  1  start request; sampled only in IDLE or DONE
- abort  in  1  synchronous abort; highest priority after rst
- busy  out  1  high from first GO state through end of RELU
- eng_start  out  1  one-cycle start pulse to the conv engine
- eng_layer  out  1  0 = conv1 pass, 1 = conv2 pass; stable while engine runs
- eng_chan  out  CH_W  channel selecting the weight slice; stable while engine runs
- eng_done  in  1  engine completion pulse; sampled only in WAIT states
- acc_row  out  RW  accumulator row address
- acc_col  out  CW  accumulator column address
- acc_we  out  1  accumulator write enable
- acc_clr  out  1  with acc_we: write conv2 result instead of adding (channel 0 only)
- relu_pass  out  1  with acc_we: write max(acc,0) (sign bit 23 set → 0)
- out_valid  out  1  final buffer valid; level signal

## Operation
- FSM states: IDLE, C1_GO, C1_WAIT, C2_GO, C2_WAIT, ACC, RELU, DONE.
- IDLE/DONE: trigger=1 → C1_GO; chan←0; out_valid cleared.
- C1_GO: eng_start=1, eng_layer=0 → C1_WAIT.
- C1_WAIT: eng_done=1 → C2_GO.
- C2_GO: eng_start=1, eng_layer=1 → C2_WAIT.
- C2_WAIT: eng_done=1 → ACC.
- ACC: raster scan, row-major, one position per cycle, P = OUT2_H*OUT2_W cycles.
  - acc_we=1 throughout; acc_clr = (chan==0).
  - At the last position (OUT2_H-1, OUT2_W-1): if chan==CHAN-1 → RELU, else chan++ → C1_GO.
- RELU: same P-cycle raster scan with acc_we=1, relu_pass=1, acc_clr=0; at the last position → DONE.
- DONE: out_valid=1, busy=0. Held until the next accepted trigger or an abort.
- trigger while busy: ignored, not queued.
- eng_done outside C1_WAIT/C2_WAIT, including the GO cycle: ignored.
- abort=1 in any state → IDLE next cycle. All outputs return to reset values and chan, row and col are zeroed.
- eng_chan = chan; eng_layer is held from GO through WAIT.
- Address counters wrap to 0 after the last position. They are zero outside ACC/RELU.

## Timing
- Reset values: every output 0, state IDLE, chan=0, row=col=0.
- rst asserted mid-operation: outputs go to reset values immediately (asynchronous). Nothing is resumed.
- All outputs are registered, or decoded from registered state only. No combinational path exists from inputs to outputs.
- Trigger sampled at edge N → C1_GO (eng_start=1, busy=1) during cycle N+1.
- With engine latency D (eng_done sampled D cycles after the GO cycle), per channel = 2·(1+D) + P cycles.
- Total from trigger to out_valid = CHAN·(2+2D+P) + P + 1 cycles.
- Simultaneous abort and trigger in DONE: abort wins → IDLE, out_valid=0.
- Simultaneous abort and eng_done: abort wins.

## Structure
- Package conv_pkg:
  - state enum
  - layer encoding constants (LAYER_C1=0, LAYER_C2=1)
  - default dimension localparams shared with the conv datapath (CHAN, OUT2_H, OUT2_W)
- One sub-module, conv_scan_cnt: row/col raster counter with en, clear and last flag. Instantiated once and reused for both the ACC and RELU scans.

## Test plan
All scenarios use CHAN=2, OUT2_H=2, OUT2_W=3 (P=6).
- Basic run: trigger, engine model answers eng_done 3 cycles after each start → 4 eng_start pulses in order (L0C0, L1C0, L0C1, L1C1). out_valid rises 2·(2+6+6)+6+1=35 cycles after trigger.
- Accumulator control:
  - Channel 0 scan: 6 writes with acc_clr=1.
  - Channel 1 scan: 6 writes with acc_clr=0.
  - RELU scan: 6 writes with relu_pass=1.
  - Addresses in all scans: (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
- Spurious inputs: eng_done pulsed during C1_GO and during ACC → ignored, sequence unchanged. trigger pulsed while busy → no restart, same 35-cycle latency.
- Abort at the 3rd ACC cycle of channel 1 → next cycle IDLE, busy=0, acc_we=0. A new trigger restarts at chan=0.
- Reset mid-C2_WAIT: rst high → all outputs 0 asynchronously. After release, IDLE, and a trigger completes a full 35-cycle run.
- Re-trigger in DONE → out_valid drops the next cycle and a new run starts.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the two-layer convolution sequencer.
//   - seq_state_e : sequencer FSM state encoding (exposed on the debug port)
//   - LAYER_C1/C2 : encoding of the eng_layer select
//   - CHAN, OUT2_H, OUT2_W : default dimensions shared with the conv datapath
package conv_pkg;

    localparam int CHAN   = 10;
    localparam int OUT2_H = 12;
    localparam int OUT2_W = 11;

    localparam logic LAYER_C1 = 1'b0;
    localparam logic LAYER_C2 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_C1_GO   = 3'd1,
        ST_C1_WAIT = 3'd2,
        ST_C2_GO   = 3'd3,
        ST_C2_WAIT = 3'd4,
        ST_ACC     = 3'd5,
        ST_RELU    = 3'd6,
        ST_DONE    = 3'd7
    } seq_state_e;

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// conv_seq_ctrl_if: engine and accumulator control bundle of the sequencer.
//   Engine side  : eng_start (1-cycle pulse), eng_layer, eng_chan, eng_done (pulse back)
//   Accum side   : acc_row, acc_col, acc_we, acc_clr, relu_pass
// Handshake: eng_start is a single-cycle request; eng_layer/eng_chan are held
// from the start cycle until the engine answers with a single-cycle eng_done.
// eng_done is only honoured while the sequencer waits for it; at any other
// time it is ignored. Accumulator writes have no back-pressure: acc_we=1
// means one write per cycle at (acc_row, acc_col).
//   master : the sequencer (drives everything except eng_done)
//   slave  : the engine/accumulator side
interface conv_seq_ctrl_if #(
    parameter int CH_W = $clog2(conv_pkg::CHAN),
    parameter int RW   = $clog2(conv_pkg::OUT2_H),
    parameter int CW   = $clog2(conv_pkg::OUT2_W)
);
    logic            eng_start;
    logic            eng_layer;
    logic [CH_W-1:0] eng_chan;
    logic            eng_done;
    logic [RW-1:0]   acc_row;
    logic [CW-1:0]   acc_col;
    logic            acc_we;
    logic            acc_clr;
    logic            relu_pass;

    modport master (
        output eng_start, eng_layer, eng_chan,
        output acc_row, acc_col, acc_we, acc_clr, relu_pass,
        input  eng_done
    );

    modport slave (
        input  eng_start, eng_layer, eng_chan,
        input  acc_row, acc_col, acc_we, acc_clr, relu_pass,
        output eng_done
    );
endinterface

// File: rtl/conv_scan_cnt.sv
// conv_scan_cnt: row-major raster counter over an H x W array.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance one position this cycle (wraps to (0,0) after the last)
//   clr      : synchronous clear to (0,0), overrides en
//   row, col : current position (registered)
//   last     : current position is (H-1, W-1)
module conv_scan_cnt #(
    parameter int H  = conv_pkg::OUT2_H,
    parameter int W  = conv_pkg::OUT2_W,
    parameter int RW = $clog2(H),
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the two-layer convolution datapath.
// For each channel it runs conv1 then conv2 on the engine, then scans the
// output accumulator (overwrite on channel 0, add on later channels). After
// the last channel a ReLU scan rewrites the buffer and out_valid is raised.
//   clk, rst   : clock, asynchronous active-high reset
//   trigger    : start request, honoured only when idle or done
//   abort      : synchronous return to idle (priority over everything but rst)
//   busy       : run in progress (first GO state through the ReLU scan)
//   out_valid  : final buffer valid (level, held in DONE)
//   dbg_state  : current FSM state
//   bus        : engine/accumulator control bundle (master side)
// Every output is decoded from registered state only.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int CHAN   = conv_pkg::CHAN,
    parameter int OUT2_H = conv_pkg::OUT2_H,
    parameter int OUT2_W = conv_pkg::OUT2_W,
    parameter int CH_W   = $clog2(CHAN),
    parameter int RW     = $clog2(OUT2_H),
    parameter int CW     = $clog2(OUT2_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            abort,
    output logic            busy,
    output logic            out_valid,
    output seq_state_e      dbg_state,
    conv_seq_ctrl_if.master bus
);
    localparam logic [CH_W-1:0] CHAN_LAST = CH_W'(CHAN - 1);

    seq_state_e      state_q, state_d;
    logic [CH_W-1:0] chan_q, chan_d;

    logic            scan_en;
    logic            scan_last;
    logic [RW-1:0]   scan_row;
    logic [CW-1:0]   scan_col;

    // One counter serves both the accumulate and the ReLU scans; it wraps to
    // (0,0) on the last position, so it is already zero whenever the FSM
    // leaves a scan state. Abort clears it explicitly.
    assign scan_en = (state_q == ST_ACC) || (state_q == ST_RELU);

    conv_scan_cnt #(
        .H  (OUT2_H),
        .W  (OUT2_W),
        .RW (RW),
        .CW (CW)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .en   (scan_en),
        .clr  (abort),
        .row  (scan_row),
        .col  (scan_col),
        .last (scan_last)
    );

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        if (abort) begin
            state_d = ST_IDLE;
            chan_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (trigger) begin
                        state_d = ST_C1_GO;
                        chan_d  = '0;
                    end
                end
                ST_C1_GO:   state_d = ST_C1_WAIT;
                ST_C1_WAIT: if (bus.eng_done) state_d = ST_C2_GO;
                ST_C2_GO:   state_d = ST_C2_WAIT;
                ST_C2_WAIT: if (bus.eng_done) state_d = ST_ACC;
                ST_ACC: begin
                    if (scan_last) begin
                        if (chan_q == CHAN_LAST) begin
                            state_d = ST_RELU;
                        end else begin
                            chan_d  = chan_q + 1'b1;
                            state_d = ST_C1_GO;
                        end
                    end
                end
                ST_RELU:    if (scan_last) state_d = ST_DONE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign dbg_state = state_q;

    assign bus.eng_start = (state_q == ST_C1_GO) || (state_q == ST_C2_GO);
    // Layer select is held across GO and WAIT so the engine sees it stable.
    assign bus.eng_layer = ((state_q == ST_C2_GO) || (state_q == ST_C2_WAIT)) ? LAYER_C2 : LAYER_C1;
    assign bus.eng_chan  = chan_q;

    assign bus.acc_row   = scan_row;
    assign bus.acc_col   = scan_col;
    assign bus.acc_we    = scan_en;
    assign bus.acc_clr   = (state_q == ST_ACC) && (chan_q == '0);
    assign bus.relu_pass = (state_q == ST_RELU);
endmodule

// File: tb/tb_conv_seq_ctrl.sv
module tb_conv_seq_ctrl;
    localparam int T_CHAN = 2;
    localparam int T_H    = 2;
    localparam int T_W    = 3;
    localparam int P      = T_H * T_W;
    localparam int CH_W   = $clog2(T_CHAN);
    localparam int RW     = $clog2(T_H);
    localparam int CW     = $clog2(T_W);
    localparam int OUT_W  = 7 + CH_W + RW + CW;

    // ---------------- clock / reset / DUT ----------------
    logic clk;
    logic rst;
    logic trigger;
    logic abort;
    logic busy;
    logic out_valid;
    conv_pkg::seq_state_e dbg_state;

    logic model_done;
    logic spur_done;

    conv_seq_ctrl_if #(.CH_W(CH_W), .RW(RW), .CW(CW)) bus ();

    assign bus.eng_done = model_done | spur_done;

    conv_seq_ctrl #(
        .CHAN   (T_CHAN),
        .OUT2_H (T_H),
        .OUT2_W (T_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trigger   (trigger),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [OUT_W-1:0] all_out;
    assign all_out = {busy, out_valid, bus.eng_start, bus.eng_layer, bus.eng_chan,
                      bus.acc_row, bus.acc_col, bus.acc_we, bus.acc_clr, bus.relu_pass};

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- engine model: eng_done D cycles after a start ----------------
    int eng_lat = 3;
    int eng_rem = 0;
    bit eng_pend = 1'b0;

    initial model_done = 1'b0;
    always @(posedge clk) begin
        #1;
        model_done = 1'b0;
        if (rst) begin
            eng_pend = 1'b0;
        end else if (bus.eng_start) begin
            eng_pend = 1'b1;
            eng_rem  = eng_lat;
        end else if (eng_pend) begin
            eng_rem--;
            if (eng_rem == 0) begin
                model_done = 1'b1;
                eng_pend   = 1'b0;
            end
        end
    end

    // ---------------- monitor: records engine starts and accumulator writes ----------------
    logic [CH_W:0]        obs_start_q[$];
    logic [RW+CW+1:0]     obs_wr_q[$];
    int                   obs_bad = 0;

    always @(posedge clk) begin
        #1;
        if (bus.eng_start) obs_start_q.push_back({bus.eng_layer, bus.eng_chan});
        if (bus.acc_we)    obs_wr_q.push_back({bus.acc_clr, bus.relu_pass, bus.acc_row, bus.acc_col});
        if (!bus.acc_we && (bus.acc_clr || bus.relu_pass || bus.acc_row != '0 || bus.acc_col != '0))
            obs_bad++;
        if (bus.acc_clr && bus.relu_pass) obs_bad++;
        if (busy && out_valid) obs_bad++;
        if (bus.eng_start && !busy) obs_bad++;
    end

    // ---------------- reference model: expected transaction lists ----------------
    logic [CH_W:0]        exp_start_q[$];
    logic [RW+CW+1:0]     exp_wr_q[$];

    function automatic void build_expected();
        exp_start_q.delete();
        exp_wr_q.delete();
        for (int c = 0; c < T_CHAN; c++) begin
            exp_start_q.push_back({1'b0, CH_W'(c)});
            exp_start_q.push_back({1'b1, CH_W'(c)});
            for (int r = 0; r < T_H; r++)
                for (int k = 0; k < T_W; k++)
                    exp_wr_q.push_back({(c == 0), 1'b0, RW'(r), CW'(k)});
        end
        for (int r = 0; r < T_H; r++)
            for (int k = 0; k < T_W; k++)
                exp_wr_q.push_back({1'b0, 1'b1, RW'(r), CW'(k)});
    endfunction

    function automatic int exp_latency(input int d);
        return T_CHAN * (2 + 2 * d + P) + P + 1;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        n_cmp++;
        if (dbg_state !== conv_pkg::ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, conv_pkg::ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) next_cycle();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h expected 0", all_out);
        end
    endtask

    // Full run from IDLE or DONE: trigger, wait for out_valid, compare the
    // recorded starts, writes and latency against the reference lists.
    task automatic test_full_run(input string name, input int d, input bit spur);
        int lat;
        int exp_lat;
        eng_lat = d;
        exp_lat = exp_latency(d);
        build_expected();
        obs_start_q.delete();
        obs_wr_q.delete();
        obs_bad = 0;
        lat = -1;
        trigger = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            next_cycle();
            trigger   = spur && (cyc == 5 || cyc == 20);
            spur_done = spur && ((bus.eng_start && !bus.eng_layer) ||
                                 (bus.acc_we && !bus.relu_pass));
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        trigger   = 1'b0;
        spur_done = 1'b0;

        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (obs_start_q.size() != exp_start_q.size()) begin
            n_bad++;
            $display("FAIL %s start_count: got %0d expected %0d", name, obs_start_q.size(), exp_start_q.size());
        end
        for (int i = 0; i < exp_start_q.size(); i++) begin
            if (i < obs_start_q.size()) begin
                n_cmp++;
                if (obs_start_q[i] !== exp_start_q[i]) begin
                    n_bad++;
                    $display("FAIL %s start[%0d] {layer,chan}: got %h expected %h", name, i, obs_start_q[i], exp_start_q[i]);
                end
            end
        end
        n_cmp++;
        if (obs_wr_q.size() != exp_wr_q.size()) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d expected %0d", name, obs_wr_q.size(), exp_wr_q.size());
        end
        for (int i = 0; i < exp_wr_q.size(); i++) begin
            if (i < obs_wr_q.size()) begin
                n_cmp++;
                if (obs_wr_q[i] !== exp_wr_q[i]) begin
                    n_bad++;
                    $display("FAIL %s write[%0d] {clr,relu,row,col}: got %h expected %h", name, i, obs_wr_q[i], exp_wr_q[i]);
                end
            end
        end
        n_cmp++;
        if (obs_bad !== 0) begin
            n_bad++;
            $display("FAIL %s output_consistency: got %0d bad cycles expected 0", name, obs_bad);
        end
        n_cmp++;
        if (busy !== 1'b0 || bus.acc_we !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done_quiet: got busy=%b we=%b expected 0 0", name, busy, bus.acc_we);
        end
        next_cycle();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s out_valid_hold: got %b expected 1", name, out_valid);
        end
    endtask

    task automatic test_basic();
        test_full_run("basic", 3, 1'b0);
    endtask

    task automatic test_spurious();
        test_full_run("spurious", 3, 1'b1);
    endtask

    task automatic test_retrigger_done();
        int lat;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL retrigger_pre: got out_valid=%b expected 1", out_valid);
        end
        eng_lat = 3;
        trigger = 1'b1;
        next_cycle();
        trigger = 1'b0;
        n_cmp++;
        if ({out_valid, busy, bus.eng_start, bus.eng_layer, bus.eng_chan} !== {4'b0110, CH_W'(0)}) begin
            n_bad++;
            $display("FAIL retrigger_go: got ov=%b busy=%b start=%b layer=%b chan=%0d expected 0 1 1 0 0",
                     out_valid, busy, bus.eng_start, bus.eng_layer, bus.eng_chan);
        end
        lat = -1;
        for (int cyc = 2; cyc <= 400; cyc++) begin
            next_cycle();
            if (out_valid) begin
                lat = cyc;
                break;
            end
        end
        n_cmp++;
        if (lat !== exp_latency(3)) begin
            n_bad++;
            $display("FAIL retrigger_latency: got %0d expected %0d", lat, exp_latency(3));
        end
    endtask

    task automatic test_abort_trigger_done();
        abort   = 1'b1;
        trigger = 1'b1;
        next_cycle();
        abort   = 1'b0;
        trigger = 1'b0;
        n_cmp++;
        if (all_out !== '0 || dbg_state !== conv_pkg::ST_IDLE) begin
            n_bad++;
            $display("FAIL abort_beats_trigger: got out=%h state=%0d expected 0 %0d", all_out, dbg_state, conv_pkg::ST_IDLE);
        end
    endtask

    task automatic test_abort();
        int  n_ch1;
        bit  hit;
        eng_lat = 3;
        n_ch1   = 0;
        hit     = 1'b0;
        trigger = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            next_cycle();
            trigger = 1'b0;
            if (bus.acc_we && !bus.acc_clr && !bus.relu_pass) n_ch1++;
            if (n_ch1 == 3) begin
                abort = 1'b1;
                hit   = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (hit !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_reach: got %b expected 1 (channel-1 scan not reached)", hit);
        end
        next_cycle();
        abort = 1'b0;
        n_cmp++;
        if (all_out !== '0 || dbg_state !== conv_pkg::ST_IDLE) begin
            n_bad++;
            $display("FAIL abort_idle: got out=%h state=%0d expected 0 %0d", all_out, dbg_state, conv_pkg::ST_IDLE);
        end
        repeat (5) next_cycle();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL abort_stays_idle: got %h expected 0", all_out);
        end
        test_full_run("after_abort", 3, 1'b0);
    endtask

    task automatic test_reset_mid();
        bit hit;
        eng_lat = 3;
        hit     = 1'b0;
        trigger = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            next_cycle();
            trigger = 1'b0;
            if (bus.eng_start && bus.eng_layer) begin
                hit = 1'b1;
                break;
            end
        end
        next_cycle();
        n_cmp++;
        if (hit !== 1'b1 || dbg_state !== conv_pkg::ST_C2_WAIT) begin
            n_bad++;
            $display("FAIL reset_mid_reach: got hit=%b state=%0d expected 1 %0d", hit, dbg_state, conv_pkg::ST_C2_WAIT);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (all_out !== '0 || dbg_state !== conv_pkg::ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_mid_async: got out=%h state=%0d expected 0 %0d", all_out, dbg_state, conv_pkg::ST_IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) next_cycle();
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_idle: got %h expected 0", all_out);
        end
        test_full_run("after_reset", 3, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int d;
            bit s;
            d = $urandom_range(1, 6);
            s = 1'($urandom_range(0, 1));
            test_full_run($sformatf("random%0d_d%0d_s%0d", it, d, s), d, s);
        end
    endtask

    initial begin
        rst       = 1'b1;
        trigger   = 1'b0;
        abort     = 1'b0;
        spur_done = 1'b0;
        test_reset();
        test_basic();
        test_spurious();
        test_retrigger_done();
        test_abort_trigger_done();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
